// File: rtl/led_lights_pkg.sv
// Shared types and constants for the LED/seven-segment display path.
// Holds the BCD converter state type and the special digit codes used by the display.
package led_lights_pkg;

    localparam int unsigned NUM_DIGITS = 4;
    localparam logic [3:0]  BCD_ERR    = 4'd10;
    localparam logic [3:0]  BCD_BLANK  = 4'd15;

    typedef enum logic [1:0] {
        IDLE,
        CONVERT,
        LOAD
    } bin2bcd_state_t;

    // Replace leading zero digits (thousands downward) with the blank code.
    // The ones digit is always kept so a zero value still shows a single '0'.
    function automatic logic [4*NUM_DIGITS-1:0] blank_leading(
        input logic [4*NUM_DIGITS-1:0] digits
    );
        logic [4*NUM_DIGITS-1:0] res;
        logic                    leading;
        res     = digits;
        leading = 1'b1;
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            if (leading && (digits[i*4 +: 4] == 4'd0)) begin
                res[i*4 +: 4] = BCD_BLANK;
            end else begin
                leading = 1'b0;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/bcd_add3_digit.sv
// Double-dabble correction for one BCD digit: add 3 when the digit is 5 or more,
// so the following left shift carries correctly into the next digit.
module bcd_add3_digit (
    input  logic [3:0] din,
    output logic [3:0] dout
);

    always_comb begin
        dout = din;
        if (din >= 4'd5) begin
            dout = din + 4'd3;
        end
    end

endmodule

// File: rtl/bin2bcd_seg_feeder.sv
// Iterative binary-to-BCD converter feeding the 4-digit seven-segment driver, one bit per clock.
// Optional feature macro: BIN2BCD_LEADING_BLANK_EN (blank leading zero digits on load).
module bin2bcd_seg_feeder
    import led_lights_pkg::*;
#(
    parameter int unsigned IN_WIDTH  = 14,
    parameter int unsigned MAX_VALUE = 9999
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [IN_WIDTH-1:0] bin_in,
    output logic                busy,
    output logic                done,
    output logic                overflow,
    output logic                valid,
    output logic [3:0]          bcd_data_0,
    output logic [3:0]          bcd_data_1,
    output logic [3:0]          bcd_data_2,
    output logic [3:0]          bcd_data_3
);

    localparam int unsigned CNT_W = $clog2(IN_WIDTH + 1);
    localparam int unsigned SCR_W = 4 * NUM_DIGITS;

    bin2bcd_state_t      state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [IN_WIDTH-1:0] bin_q, bin_d;
    logic [SCR_W-1:0]    scr_q, scr_d;
    logic                ovf_q, ovf_d;
    logic [SCR_W-1:0]    digits_q, digits_d;
    logic                done_q, done_d;
    logic                overflow_q, overflow_d;
    logic                valid_q, valid_d;

    logic [SCR_W-1:0]    scr_adj;
    logic [SCR_W-1:0]    load_val;
    logic                in_range;
    logic                unused_scr_msb;

    assign in_range = (32'(bin_in) <= MAX_VALUE);

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_add3
        bcd_add3_digit u_add3 (
            .din  (scr_q[g*4 +: 4]),
            .dout (scr_adj[g*4 +: 4])
        );
    end

    // The range check keeps the top digit below 8, so nothing is ever shifted out here.
    assign unused_scr_msb = scr_adj[SCR_W-1];

    always_comb begin
        load_val = scr_q;
        if (ovf_q) begin
            load_val = {NUM_DIGITS{BCD_ERR}};
        end else begin
`ifdef BIN2BCD_LEADING_BLANK_EN
            load_val = blank_leading(scr_q);
`else
            load_val = scr_q;
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bin_d      = bin_q;
        scr_d      = scr_q;
        ovf_d      = ovf_q;
        digits_d   = digits_q;
        done_d     = 1'b0;
        overflow_d = overflow_q;
        valid_d    = valid_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    bin_d = bin_in;
                    scr_d = '0;
                    cnt_d = CNT_W'(IN_WIDTH);
                    if (in_range) begin
                        ovf_d   = 1'b0;
                        state_d = CONVERT;
                    end else begin
                        ovf_d   = 1'b1;
                        state_d = LOAD;
                    end
                end
            end
            CONVERT: begin
                scr_d = {scr_adj[SCR_W-2:0], bin_q[IN_WIDTH-1]};
                bin_d = bin_q << 1;
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                digits_d   = load_val;
                overflow_d = ovf_q;
                done_d     = 1'b1;
                valid_d    = 1'b1;
                state_d    = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            bin_q      <= '0;
            scr_q      <= '0;
            ovf_q      <= 1'b0;
            digits_q   <= '0;
            done_q     <= 1'b0;
            overflow_q <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bin_q      <= bin_d;
            scr_q      <= scr_d;
            ovf_q      <= ovf_d;
            digits_q   <= digits_d;
            done_q     <= done_d;
            overflow_q <= overflow_d;
            valid_q    <= valid_d;
        end
    end

    assign busy       = (state_q != IDLE);
    assign done       = done_q;
    assign overflow   = overflow_q;
    assign valid      = valid_q;
    assign bcd_data_0 = digits_q[3:0];
    assign bcd_data_1 = digits_q[7:4];
    assign bcd_data_2 = digits_q[11:8];
    assign bcd_data_3 = digits_q[15:12];

endmodule

// File: tb/tb_bin2bcd_seg_feeder.sv
// Directed bench for bin2bcd_seg_feeder: expected digits are queued when a value is
// driven and compared when the converter reports done.
module tb_bin2bcd_seg_feeder;

    localparam int unsigned IW   = 14;
    localparam int unsigned MAXV = 9999;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [IW-1:0] bin_in;
    logic          busy;
    logic          done;
    logic          overflow;
    logic          valid;
    logic [3:0]    d0, d1, d2, d3;
    logic [15:0]   digits;

    int            total = 0;
    int            bad   = 0;
    logic [16:0]   exp_q[$];
    int unsigned   b2b[6] = '{1111, 10000, 8, 9999, 16383, 305};

    always #5 clk = ~clk;

    assign digits = {d3, d2, d1, d0};

    bin2bcd_seg_feeder #(
        .IN_WIDTH  (IW),
        .MAX_VALUE (MAXV)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .bin_in     (bin_in),
        .busy       (busy),
        .done       (done),
        .overflow   (overflow),
        .valid      (valid),
        .bcd_data_0 (d0),
        .bcd_data_1 (d1),
        .bcd_data_2 (d2),
        .bcd_data_3 (d3)
    );

    // {overflow, thousands, hundreds, tens, ones}
    function automatic logic [16:0] model(input int unsigned v);
        logic [3:0] th, hu, te, on;
        if (v > MAXV) return {1'b1, 16'hAAAA};
        th = 4'(v / 1000);
        hu = 4'((v / 100) % 10);
        te = 4'((v / 10) % 10);
        on = 4'(v % 10);
`ifdef BIN2BCD_LEADING_BLANK_EN
        if (th == 4'd0) begin
            th = 4'hF;
            if (hu == 4'd0) begin
                hu = 4'hF;
                if (te == 4'd0) te = 4'hF;
            end
        end
`endif
        return {1'b0, th, hu, te, on};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_conv(input int unsigned v, input bit poke);
        int          c;
        logic [16:0] e;
        @(negedge clk);
        bin_in = IW'(v);
        start  = 1'b1;
        exp_q.push_back(model(v));
        @(negedge clk);
        start  = 1'b0;
        bin_in = ~bin_in;
        chk("busy_after_start", 32'(busy), 32'd1);
        c = 0;
        while (!done && c < 40) begin
            if (poke && c == 3) begin
                start  = 1'b1;
                bin_in = IW'(555);
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            c++;
        end
        start = 1'b0;
        chk("latency", 32'(c), (v > MAXV) ? 32'd1 : 32'(IW + 1));
        e = exp_q.pop_front();
        chk("digits", 32'(digits), 32'(e[15:0]));
        chk("overflow", 32'(overflow), 32'(e[16]));
        chk("valid", 32'(valid), 32'd1);
        chk("busy_in_done", 32'(busy), 32'd0);
        @(negedge clk);
        chk("done_width", 32'(done), 32'd0);
        chk("digits_hold", 32'(digits), 32'(e[15:0]));
        chk("valid_sticky", 32'(valid), 32'd1);
    endtask

    initial begin
        int          idx;
        int          ndone;
        int          cyc;
        bit          extra_done;
        logic [16:0] e;

        rst_n  = 1'b0;
        start  = 1'b0;
        bin_in = '0;
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_valid", 32'(valid), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        chk("rst_digits", 32'(digits), 32'd0);
        rst_n = 1'b1;

        do_conv(1234, 1'b0);
        do_conv(0, 1'b0);
        do_conv(507, 1'b0);
        do_conv(9999, 1'b0);
        do_conv(10000, 1'b0);
        do_conv(16383, 1'b0);
        do_conv(10, 1'b0);

        // A start while busy must neither disturb the result nor queue a second conversion.
        do_conv(8765, 1'b1);
        extra_done = 1'b0;
        repeat (IW + 4) begin
            @(negedge clk);
            if (done) extra_done = 1'b1;
        end
        chk("start_ignored_when_busy", 32'(extra_done), 32'd0);

        // start held high: only the value present in each idle cycle is converted.
        @(negedge clk);
        start  = 1'b1;
        bin_in = IW'(b2b[0]);
        exp_q.push_back(model(b2b[0]));
        idx   = 1;
        ndone = 0;
        cyc   = 0;
        while (ndone < 6 && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (done) begin
                e = exp_q.pop_front();
                chk("b2b_digits", 32'(digits), 32'(e[15:0]));
                chk("b2b_overflow", 32'(overflow), 32'(e[16]));
                ndone++;
                if (idx < 6) begin
                    bin_in = IW'(b2b[idx]);
                    exp_q.push_back(model(b2b[idx]));
                    idx++;
                end else begin
                    start = 1'b0;
                end
            end else begin
                bin_in = IW'($urandom_range(0, 16383));
            end
        end
        start = 1'b0;
        chk("b2b_count", 32'(ndone), 32'd6);
        chk("b2b_queue_drained", 32'(exp_q.size()), 32'd0);
        repeat (2) @(negedge clk);

        // Reset in the middle of a conversion discards it.
        bin_in = IW'(4321);
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        chk("midrst_valid", 32'(valid), 32'd0);
        chk("midrst_overflow", 32'(overflow), 32'd0);
        chk("midrst_digits", 32'(digits), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("valid_before_first_done", 32'(valid), 32'd0);
        do_conv(42, 1'b0);

        for (int v = 0; v <= int'(MAXV); v += 53) begin
            do_conv(v, 1'b0);
        end
        do_conv(MAXV, 1'b0);
        do_conv(MAXV + 1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
